// File: rtl/multiword_add_seq.sv
// multiword_add_seq: streams WORDS x 32-bit add/subtract operations through an
// external 32-bit combinational adder, least-significant word first. The adder
// inputs are driven straight from the presented word. The 33-bit adder result
// is captured into a one-deep output register. The carry is fed back to the
// next word of the same operation.
module multiword_add_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_cin,
  input  logic        in_sub,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [32:0] add_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_last,
  output logic        out_carry,
  output logic        busy
);

  localparam int unsigned   CW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          sub_q, sub_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_sum_q, out_sum_d;
  logic          out_last_q, out_last_d;
  logic          out_carry_q, out_carry_d;

  logic first;
  logic eff_sub;
  logic is_last;
  logic accept;

  // Adder drive and handshake: purely combinational from the presented word.
  always_comb begin
    first    = (cnt_q == '0);
    is_last  = (cnt_q == LAST);
    eff_sub  = first ? in_sub : sub_q;
    add_a    = in_a;
    add_b    = eff_sub ? ~in_b : in_b;
    // Word 0 of a subtract forces the +1 of the two's complement.
    add_cin  = first ? (in_sub | in_cin) : carry_q;
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;
  end

  // Next-state: capture adder result on accept, otherwise drain or hold.
  always_comb begin
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_carry_d = out_carry_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_sum_d   = add_sum[31:0];
      carry_d     = add_sum[32];
      out_last_d  = is_last;
      out_carry_d = is_last ? add_sum[32] : 1'b0;
      if (first) begin
        sub_d = in_sub;
      end
      cnt_d = is_last ? '0 : cnt_q + 1'b1;
    end else if (out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_carry_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_carry_q <= out_carry_d;
    end
  end

  // Output register fields and status.
  always_comb begin
    out_valid = out_valid_q;
    out_sum   = out_sum_q;
    out_last  = out_last_q;
    out_carry = out_carry_q;
    busy      = (cnt_q != '0);
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Testbench for multiword_add_seq: a WORDS=4 instance and a WORDS=1 instance.
// Each instance has a behavioural 32-bit adder attached. Expected results come
// from whole-operand wide arithmetic.
module tb_multiword_add_seq;

  localparam int unsigned NW = 4;
  localparam int unsigned BW = 32 * NW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WORDS=4 instance signals
  logic        in_valid, in_ready, in_cin, in_sub;
  logic [31:0] in_a, in_b, add_a, add_b, out_sum;
  logic        add_cin, out_valid, out_ready, out_last, out_carry, busy;
  logic [32:0] add_sum;

  // WORDS=1 instance signals
  logic        s_in_valid, s_in_ready, s_in_cin, s_in_sub;
  logic [31:0] s_in_a, s_in_b, s_add_a, s_add_b, s_out_sum;
  logic        s_add_cin, s_out_valid, s_out_ready, s_out_last, s_out_carry, s_busy;
  logic [32:0] s_add_sum;

  assign add_sum   = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);
  assign s_add_sum = {1'b0, s_add_a} + {1'b0, s_add_b} + 33'(s_add_cin);

  multiword_add_seq #(.WORDS(NW)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_last(out_last), .out_carry(out_carry), .busy(busy)
  );

  multiword_add_seq #(.WORDS(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
    .in_cin(s_in_cin), .in_sub(s_in_sub),
    .add_a(s_add_a), .add_b(s_add_b), .add_cin(s_add_cin), .add_sum(s_add_sum),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum),
    .out_last(s_out_last), .out_carry(s_out_carry), .busy(s_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Runs (up to nw words of) one operation on the WORDS=4 instance.
  // stall_at > 0: hold out_ready low for 3 cycles while word stall_at is presented.
  // gaps bit w (w > 0): insert one idle cycle with garbage inputs before word w.
  task automatic do_op(input logic [BW-1:0] a, input logic [BW-1:0] b,
                       input logic cin, input logic sub,
                       input int stall_at, input int nw, input logic [31:0] gaps);
    logic [BW-1:0] beff;
    logic [BW:0]   res, mask, part;
    logic          c0, fin;
    c0   = sub ? 1'b1 : cin;
    beff = sub ? ~b : b;
    res  = {1'b0, a} + {1'b0, beff} + (BW+1)'(c0);
    fin  = sub ? (a >= b) : res[BW];
    for (int w = 0; w < nw; w++) begin
      if (w > 0 && gaps[w]) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom); in_sub = 1'($urandom);
        @(posedge clk); #1;
        chk1("gap_out_valid", out_valid, 1'b0);
        chk32("gap_out_sum_hold", out_sum, res[32*(w-1) +: 32]);
        chk1("gap_busy", busy, 1'b1);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a[32*w +: 32];
      in_b     = b[32*w +: 32];
      in_cin   = cin;
      in_sub   = sub;
      if (w > 0) begin
        in_cin = 1'($urandom);
        in_sub = 1'($urandom);
      end
      mask = ((BW+1)'(1) << (32*w)) - (BW+1)'(1);
      part = (({1'b0, a} & mask) + ({1'b0, beff} & mask) + (BW+1)'(c0)) >> (32*w);
      #1;
      if (w == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk1("bp_in_ready", in_ready, 1'b0);
          chk1("bp_out_valid", out_valid, 1'b1);
          chk32("bp_out_sum_hold", out_sum, res[32*(w-1) +: 32]);
          @(posedge clk); #1;
        end
        chk32("bp_out_sum_after", out_sum, res[32*(w-1) +: 32]);
        out_ready = 1'b1;
        #1;
      end
      chk32("add_a", add_a, a[32*w +: 32]);
      chk32("add_b", add_b, beff[32*w +: 32]);
      chk1("add_cin", add_cin, part[0]);
      chk1("in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      chk1("out_valid", out_valid, 1'b1);
      chk32("out_sum", out_sum, res[32*w +: 32]);
      chk1("out_last", out_last, w == NW - 1);
      chk1("out_carry", out_carry, (w == NW - 1) ? fin : 1'b0);
      chk1("busy", busy, w != NW - 1);
    end
  endtask

  initial begin
    logic [BW-1:0] ra, rb, ones;
    logic [31:0]   sa, sb;
    logic          sc, ss, s_fin;
    logic [32:0]   sr;

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_cin = 1'b0; s_in_sub = 1'b0;
    s_out_ready = 1'b1;
    ones = '1;

    repeat (2) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk32("rst_out_sum", out_sum, 32'h0);
    chk1("rst_out_last", out_last, 1'b0);
    chk1("rst_out_carry", out_carry, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst1_out_valid", s_out_valid, 1'b0);
    chk1("rst1_busy", s_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // All-ones + 1: carry ripples out of the top word.
    do_op(ones, BW'(1), 1'b0, 1'b0, -1, NW, '0);
    // Immediately followed by 0 + 0: no carry may leak across the wrap.
    do_op('0, '0, 1'b0, 1'b0, -1, NW, '0);
    // Subtract 1 - 2 (borrow) and 2 - 1 (no borrow).
    do_op(BW'(1), BW'(2), 1'b0, 1'b1, -1, NW, '0);
    do_op(BW'(2), BW'(1), 1'b1, 1'b1, -1, NW, '0);
    // Backpressure while word 2 is presented, with a live carry chain.
    do_op(ones, BW'(1), 1'b0, 1'b0, 2, NW, '0);

    // Reset after two words of an operation discards the partial result.
    for (int i = 0; i < NW; i++) begin
      ra[32*i +: 32] = $urandom;
      rb[32*i +: 32] = $urandom;
    end
    do_op(ra, rb, 1'b1, 1'b0, -1, 2, '0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    do_op(BW'(5), BW'(7), 1'b1, 1'b0, -1, NW, '0);

    // Random operations with idle gaps between words.
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NW; i++) begin
        ra[32*i +: 32] = $urandom;
        rb[32*i +: 32] = $urandom;
      end
      if (k == 3) rb = ra;
      if (k == 4) rb[BW-1 -: 32] = ra[BW-1 -: 32];
      do_op(ra, rb, 1'($urandom), (k % 2 == 1) ? 1'b1 : 1'($urandom), -1, NW, $urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;

    // WORDS=1: every word is both first and last.
    for (int k = 0; k < 10; k++) begin
      if (k < 3) begin
        sa = 32'hFFFF_FFFF; sb = 32'h1; sc = 1'b1; ss = 1'b0;
      end else begin
        sa = $urandom; sb = $urandom; sc = 1'($urandom); ss = 1'($urandom);
        if (k == 5) sb = sa;
      end
      if (ss) begin
        sr    = {1'b0, sa} - {1'b0, sb};
        s_fin = (sa >= sb);
      end else begin
        sr    = {1'b0, sa} + {1'b0, sb} + 33'(sc);
        s_fin = sr[32];
      end
      @(negedge clk);
      s_in_valid = 1'b1; s_in_a = sa; s_in_b = sb; s_in_cin = sc; s_in_sub = ss;
      #1;
      chk1("w1_add_cin", s_add_cin, ss | sc);
      @(posedge clk); #1;
      chk1("w1_out_valid", s_out_valid, 1'b1);
      chk32("w1_out_sum", s_out_sum, sr[31:0]);
      chk1("w1_out_last", s_out_last, 1'b1);
      chk1("w1_out_carry", s_out_carry, s_fin);
      chk1("w1_busy", s_busy, 1'b0);
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    @(posedge clk); #1;
    chk1("w1_drain", s_out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
